// File: rtl/kv_flow_table_pkg.sv
// Shared types for the flow-state table: FSM states, request op codes,
// stored status values and the reply flag layout.
package kv_flow_table_pkg;

    // Controller states; INIT sweeps the table clear after every reset.
    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_CMP  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    // Request op carried in in_flag[2:1].
    typedef enum logic [1:0] {
        OP_LOOKUP  = 2'b00,
        OP_SUSPECT = 2'b01,
        OP_ARREST  = 2'b10,
        OP_DELETE  = 2'b11
    } op_e;

    // Per-flow status; FILTERE is produced by a later filter stage, never by this table.
    typedef enum logic [1:0] {
        STATUS_NONE    = 2'b00,
        STATUS_SUSPECT = 2'b01,
        STATUS_ARREST  = 2'b10,
        STATUS_FILTERE = 2'b11
    } status_e;

    // Bit position of the op-valid qualifier inside in_flag.
    localparam int FLAG_OP_VALID = 0;

    // Reply layout: [3]=collision, [2:1]=resulting status, [0]=hit.
    typedef struct packed {
        logic    coll;
        status_e status;
        logic    hit;
    } reply_t;

endpackage

// File: rtl/kv_flow_table_if.sv
// Request/reply bus between the packet parser (master) and the flow table (slave).
interface kv_flow_table_if #(
    parameter int KEY_SIZE = 96
);
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    logic                out_valid;
    logic [3:0]          out_flag;
    logic                busy;
    logic [15:0]         drop_cnt;

    modport master (
        output in_key, in_flag, in_valid,
        input  out_valid, out_flag, busy, drop_cnt
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output out_valid, out_flag, busy, drop_cnt
    );
endinterface

// File: rtl/kv_flow_table_ram.sv
// Single-port table memory with a registered (1-cycle) read; read returns
// the contents from before a same-cycle write.
module kv_sp_ram #(
    parameter int WIDTH  = 99,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read share one address.
    // NOTE: the array has no reset branch so it maps onto block RAM; the
    // controller's INIT sweep is what clears it after reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kv_flow_table.sv
// Direct-mapped flow-state table behind the DNS/ICMP parser. One request at
// a time: capture (IDLE), read (RD), compare/update (CMP), reply (RSP).
module kv_flow_table
    import kv_flow_table_pkg::*;
#(
    parameter int KEY_SIZE  = 96,
    parameter int HASH_BITS = 10
) (
    input logic            clk156,
    input logic            eth_rst,
    kv_flow_table_if.slave bus
);

    localparam int ENTRY_W = 1 + 2 + KEY_SIZE;
    localparam int DEPTH   = 2 ** HASH_BITS;

    typedef logic [HASH_BITS-1:0] idx_t;

    // Bit i of the key lands in index bit (i mod HASH_BITS); identical to
    // XOR-ing HASH_BITS-wide chunks with a zero-padded last chunk.
    function automatic idx_t hash_fold(input logic [KEY_SIZE-1:0] key);
        idx_t h;
        h = '0;
        for (int i = 0; i < KEY_SIZE; i++) begin
            h[i % HASH_BITS] ^= key[i];
        end
        return h;
    endfunction

    state_e              state_q, state_d;
    idx_t                init_idx_q;
    idx_t                idx_q;
    logic [KEY_SIZE-1:0] key_q;
    op_e                 op_q;
    reply_t              rsp_q, rsp_d;
    logic                out_valid_q;
    reply_t              out_flag_q;
    logic [15:0]         drop_cnt_q;

    idx_t                ram_addr;
    logic                ram_we;
    logic [ENTRY_W-1:0]  ram_wdata;
    logic [ENTRY_W-1:0]  ram_rdata;

    logic                cmp_we;
    logic [ENTRY_W-1:0]  cmp_wdata;
    logic                busy;
    logic                req;
    logic                unused_reserved;

    // Only requests with the op-valid bit set are real; in_flag[3] is reserved.
    assign req             = bus.in_valid & bus.in_flag[FLAG_OP_VALID];
    assign unused_reserved = bus.in_flag[3];

    // Stored entry fields as read back during CMP.
    logic                s_valid;
    status_e             s_status;
    logic [KEY_SIZE-1:0] s_key;
    logic                hit;
    logic                coll;

    assign s_valid  = ram_rdata[ENTRY_W-1];
    assign s_status = status_e'(ram_rdata[KEY_SIZE +: 2]);
    assign s_key    = ram_rdata[KEY_SIZE-1:0];
    assign hit      = s_valid && (s_key == key_q);
    // An occupied slot held by a different key is reported on every miss.
    assign coll     = s_valid && !hit;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from the pre-edge values.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-step request walk after the init sweep.
    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (init_idx_q == idx_t'(DEPTH - 1)) state_d = ST_IDLE;
            ST_IDLE: if (req) state_d = ST_RD;
            ST_RD:   state_d = ST_CMP;
            ST_CMP:  state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // State-decoded outputs: busy flag and RAM port steering.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        ram_addr  = idx_q;
        ram_we    = 1'b0;
        ram_wdata = cmp_wdata;
        unique case (state_q)
            ST_INIT: begin
                ram_addr  = init_idx_q;
                ram_we    = 1'b1;
                ram_wdata = '0;
            end
            ST_CMP:  ram_we = cmp_we;
            default: ;
        endcase
    end

    // Op semantics: decide the single write (if any) and the reply word.
    always_comb begin
        cmp_we        = 1'b0;
        cmp_wdata     = {1'b1, STATUS_SUSPECT, key_q};
        rsp_d.coll    = coll;
        rsp_d.status  = STATUS_NONE;
        rsp_d.hit     = hit;
        unique case (op_q)
            OP_LOOKUP: begin
                if (hit) rsp_d.status = s_status;
            end
            OP_SUSPECT: begin
                if (hit) begin
                    // Never downgrade an existing entry.
                    rsp_d.status = s_status;
                end else begin
                    cmp_we       = 1'b1;
                    rsp_d.status = STATUS_SUSPECT;
                end
            end
            OP_ARREST: begin
                if (hit) begin
                    cmp_we       = 1'b1;
                    cmp_wdata    = {1'b1, STATUS_ARREST, key_q};
                    rsp_d.status = STATUS_ARREST;
                end
            end
            OP_DELETE: begin
                if (hit) begin
                    cmp_we    = 1'b1;
                    cmp_wdata = '0;
                end
            end
            default: ;
        endcase
    end

    // Init sweep pointer: one table slot cleared per cycle while in INIT.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            init_idx_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_idx_q <= init_idx_q + 1'b1;
        end
    end

    // Request capture: key, op and hashed index latched on acceptance.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            key_q <= '0;
            op_q  <= OP_LOOKUP;
            idx_q <= '0;
        end else if ((state_q == ST_IDLE) && req) begin
            key_q <= bus.in_key;
            op_q  <= op_e'(bus.in_flag[2:1]);
            idx_q <= hash_fold(bus.in_key);
        end
    end

    // Pending reply computed in CMP, held until RSP publishes it.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            rsp_q <= '0;
        end else if (state_q == ST_CMP) begin
            rsp_q <= rsp_d;
        end
    end

    // Reply register: one-cycle strobe, flag held until the next reply.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
        end else begin
            out_valid_q <= (state_q == ST_RSP);
            if (state_q == ST_RSP) begin
                out_flag_q <= rsp_q;
            end
        end
    end

    // Saturating count of requests refused because the table was busy.
    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            drop_cnt_q <= '0;
        end else if (req && busy && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    kv_sp_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk156),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.busy      = busy;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule
